// File: rtl/umem_pkg.sv
// Shared types for the unified-memory arbiter: FSM states, grant owner and
// fixed widths used by the top and the priority selector.
package umem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DATA  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_D  = 1'b1
    } gnt_t;

    localparam logic [3:0] BE_FULL  = 4'hF;
    localparam int         STREAK_W = 4;
    localparam int         TCNT_W   = 10;

endpackage

// File: rtl/umem_prio_sel.sv
// Combinational grant selection between fetch and data requests, with the
// fetch-starvation limit and the misalignment flag for the winning request.
module umem_prio_sel
    import umem_pkg::*;
#(
    parameter int MAX_STREAK = 4
) (
    input  logic                if_req,
    input  logic                d_req,
    input  logic [1:0]          if_addr_lo,
    input  logic [1:0]          d_addr_lo,
    input  logic [STREAK_W-1:0] streak,
    output logic                valid,
    output gnt_t                gnt,
    output logic                misalign
);

    // NOTE: every output gets a default before any condition so no latch is inferred.
    always_comb begin
        valid    = if_req | d_req;
        gnt      = GNT_D;
        misalign = 1'b0;
        if (if_req && (!d_req || streak == STREAK_W'(MAX_STREAK)))
            gnt = GNT_IF;
        if (gnt == GNT_IF)
            misalign = |if_addr_lo;
        else
            misalign = |d_addr_lo;
    end

endmodule

// File: rtl/umem_arbiter.sv
// Shares one single-ported instruction/data memory between the fetch and
// load/store paths, one transaction at a time, with registered outputs.
module umem_arbiter
    import umem_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_STREAK = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,
    output logic              if_busy,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              d_busy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [TCNT_W-1:0] TMO_LAST = TCNT_W'(TIMEOUT - 1);

    state_t                state;
    gnt_t                  gnt;
    logic [STREAK_W-1:0]   streak;
    logic [TCNT_W-1:0]     tcnt;
    logic [DATA_W-1:0]     resp_data;
    logic                  resp_err;

    logic                  sel_valid;
    logic                  sel_misalign;
    gnt_t                  sel_gnt;
    logic                  arb_en;
    logic [ADDR_W-1:0]     sel_addr;

    assign if_busy = if_req & ~if_done;
    assign d_busy  = d_req & ~d_done;

    // A requester still holds req during its done cycle, so no grant is made
    // then; this is the mandatory idle cycle between transactions.
    assign arb_en   = (state == ST_IDLE) && !if_done && !d_done;
    assign sel_addr = (sel_gnt == GNT_IF) ? if_addr : d_addr;

    umem_prio_sel #(
        .MAX_STREAK (MAX_STREAK)
    ) u_prio_sel (
        .if_req     (if_req),
        .d_req      (d_req),
        .if_addr_lo (if_addr[1:0]),
        .d_addr_lo  (d_addr[1:0]),
        .streak     (streak),
        .valid      (sel_valid),
        .gnt        (sel_gnt),
        .misalign   (sel_misalign)
    );

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples the values from before this clock edge.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= ST_IDLE;
            gnt       <= GNT_IF;
            streak    <= '0;
            tcnt      <= '0;
            resp_data <= '0;
            resp_err  <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_done   <= 1'b0;
            if_rdata  <= '0;
            if_err    <= 1'b0;
            d_done    <= 1'b0;
            d_rdata   <= '0;
            d_err     <= 1'b0;
        end else begin
            if_done <= 1'b0;
            if_err  <= 1'b0;
            d_done  <= 1'b0;
            d_err   <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (arb_en && sel_valid) begin
                        gnt  <= sel_gnt;
                        tcnt <= '0;
                        if (sel_gnt == GNT_IF || !if_req)
                            streak <= '0;
                        else if (streak != STREAK_W'(MAX_STREAK))
                            streak <= streak + 1'b1;

                        if (sel_misalign) begin
                            resp_data <= '0;
                            resp_err  <= 1'b1;
                            state     <= ST_RESP;
                        end else begin
                            mem_req  <= 1'b1;
                            mem_addr <= {sel_addr[ADDR_W-1:2], 2'b00};
                            if (sel_gnt == GNT_IF) begin
                                mem_we    <= 1'b0;
                                mem_be    <= BE_FULL;
                                mem_wdata <= '0;
                                state     <= ST_FETCH;
                            end else begin
                                mem_we    <= d_we;
                                mem_be    <= d_we ? d_be : BE_FULL;
                                mem_wdata <= d_wdata;
                                state     <= ST_DATA;
                            end
                        end
                    end
                end

                ST_FETCH, ST_DATA: begin
                    // An ack arriving in the timeout cycle takes precedence.
                    if (mem_ack) begin
                        mem_req   <= 1'b0;
                        resp_data <= mem_rdata;
                        resp_err  <= 1'b0;
                        state     <= ST_RESP;
                    end else if (TIMEOUT != 0 && tcnt == TMO_LAST) begin
                        mem_req   <= 1'b0;
                        resp_data <= '0;
                        resp_err  <= 1'b1;
                        state     <= ST_RESP;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end

                ST_RESP: begin
                    if (gnt == GNT_IF) begin
                        if_done  <= 1'b1;
                        if_rdata <= resp_data;
                        if_err   <= resp_err;
                    end else begin
                        d_done  <= 1'b1;
                        d_rdata <= resp_data;
                        d_err   <= resp_err;
                    end
                    state <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_umem_arbiter.sv
// Self-checking bench for umem_arbiter: directed scenarios plus randomized
// single transactions checked against a transaction-level reference model.
module tb_umem_arbiter;

    localparam int TMO  = 8;
    localparam int MAXS = 4;

    logic        clk;
    logic        nrst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_rdata;
    logic        if_err;
    logic        if_busy;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        d_busy;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];
    int          ack_delay;
    int          n_checks;
    int          n_pass;
    int          n_fail;
    logic [31:0] exp_last_if;
    logic [31:0] exp_last_d;

    umem_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .MAX_STREAK (MAXS),
        .TIMEOUT    (TMO)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_done   (if_done),
        .if_rdata  (if_rdata),
        .if_err    (if_err),
        .if_busy   (if_busy),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_be      (d_be),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_done    (d_done),
        .d_rdata   (d_rdata),
        .d_err     (d_err),
        .d_busy    (d_busy),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Memory responder: acks on the ack_delay-th cycle of a request (0 = never).
    initial begin : responder
        int req_cyc;
        req_cyc   = 0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            if (mem_req === 1'b1) begin
                req_cyc++;
                if (ack_delay != 0 && req_cyc == ack_delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem[mem_addr[9:2]];
                    if (mem_we) mem[mem_addr[9:2]] = merge(mem[mem_addr[9:2]], mem_wdata, mem_be);
                end
            end else begin
                req_cyc = 0;
            end
        end
    end

    // One isolated transaction on one port; starts and ends on a falling edge.
    task automatic do_txn(input bit is_d, input bit we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wdata, input int ack_d);
        int          k;
        int          exp_k;
        int          req_hi;
        int          exp_hi;
        bit          seen;
        bit          mis;
        bit          tmo;
        bit          exp_err;
        logic [31:0] exp_rd;
        string       p;
        p       = is_d ? "d" : "if";
        mis     = (addr[1:0] != 2'b00);
        tmo     = !mis && (ack_d == 0 || ack_d > TMO);
        exp_err = mis || tmo;
        exp_k   = mis ? 2 : (tmo ? TMO + 2 : ack_d + 2);
        exp_hi  = mis ? 0 : (tmo ? TMO : ack_d);
        exp_rd  = exp_err ? 32'h0 : ref_mem[addr[9:2]];
        ack_delay = ack_d;
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_be = be; d_addr = addr; d_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        k = 0; req_hi = 0; seen = 1'b0;
        while (!seen && k < 40) begin
            @(posedge clk);
            @(negedge clk);
            k++;
            if (mem_req) req_hi++;
            if (k == 1) begin
                check({p, "_mem_req_first"}, mem_req, !mis);
                check({p, "_busy_wait"}, is_d ? d_busy : if_busy, 1);
                if (!mis) begin
                    check({p, "_mem_addr"}, mem_addr, {addr[31:2], 2'b00});
                    check({p, "_mem_we"}, mem_we, is_d && we);
                    check({p, "_mem_be"}, mem_be, (is_d && we) ? be : 4'hF);
                    if (is_d && we) check("d_mem_wdata", mem_wdata, wdata);
                end
            end
            if (is_d ? d_done : if_done) seen = 1'b1;
        end
        check({p, "_done_seen"}, seen, 1);
        check({p, "_latency"}, k, exp_k);
        check({p, "_mem_req_cycles"}, req_hi, exp_hi);
        check({p, "_err"}, is_d ? d_err : if_err, exp_err);
        check({p, "_rdata"}, is_d ? d_rdata : if_rdata, exp_rd);
        check({p, "_busy_done"}, is_d ? d_busy : if_busy, 0);
        check({p, "_other_done"}, is_d ? if_done : d_done, 0);
        check({p, "_other_rdata_hold"}, is_d ? if_rdata : d_rdata, is_d ? exp_last_if : exp_last_d);
        if (is_d) exp_last_d = exp_rd; else exp_last_if = exp_rd;
        if (is_d && we && !exp_err) ref_mem[addr[9:2]] = merge(ref_mem[addr[9:2]], wdata, be);
        if_req = 1'b0;
        d_req  = 1'b0;
        @(negedge clk);
    endtask

    initial begin : main
        int          k;
        int          n;
        int          n_rise;
        int          dk;
        int          ik;
        int          d_run;
        bit          prev;
        int          got   [10];
        int          exp_o [10];
        logic [31:0] exp_d;
        logic [31:0] exp_i;
        logic [31:0] a;
        bit          is_d;
        bit          we;

        n_checks = 0; n_pass = 0; n_fail = 0;
        exp_last_if = '0; exp_last_d = '0;
        ack_delay = 1;
        nrst = 1'b0;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 32'h1000_0000 + i * 32'h0101_0003;
            ref_mem[i] = mem[i];
        end
        mem[16]     = 32'h2008_000A;
        ref_mem[16] = 32'h2008_000A;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_be", mem_be, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_if_done", if_done, 0);
        check("rst_d_done", d_done, 0);
        check("rst_if_rdata", if_rdata, 0);
        check("rst_d_rdata", d_rdata, 0);
        check("rst_errs", {if_err, d_err}, 0);
        check("rst_busy", {if_busy, d_busy}, 0);
        nrst = 1'b1;
        @(negedge clk);

        // Fetch only, zero-wait memory
        do_txn(1'b0, 1'b0, 4'hF, 32'h40, 32'h0, 1);

        // Simultaneous store and fetch: data first, fetch after one idle cycle
        ack_delay = 1;
        d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h100; d_wdata = 32'h0000_BEEF;
        if_req = 1'b1; if_addr = 32'h44;
        exp_d = ref_mem[64];
        exp_i = ref_mem[17];
        k = 0; n_rise = 0; prev = 1'b0; dk = 0; ik = 0;
        while ((d_req || if_req) && k < 30) begin
            @(posedge clk);
            @(negedge clk);
            k++;
            if (mem_req && !prev) begin
                if (n_rise == 0) begin
                    check("both_first_addr", mem_addr, 32'h100);
                    check("both_first_we", mem_we, 1);
                    check("both_first_be", mem_be, 4'b0011);
                    check("both_first_wdata", mem_wdata, 32'h0000_BEEF);
                end else begin
                    check("both_second_addr", mem_addr, 32'h44);
                    check("both_second_we", mem_we, 0);
                    check("both_second_be", mem_be, 4'hF);
                end
                n_rise++;
            end
            prev = mem_req;
            if (d_done && d_req) begin
                dk = k;
                check("both_d_err", d_err, 0);
                check("both_d_rdata", d_rdata, exp_d);
                d_req = 1'b0;
            end
            if (if_done && if_req) begin
                ik = k;
                check("both_if_err", if_err, 0);
                check("both_if_rdata", if_rdata, exp_i);
                if_req = 1'b0;
            end
        end
        check("both_d_latency", dk, 3);
        check("both_if_latency", ik, 7);
        check("both_mem_txns", n_rise, 2);
        ref_mem[64] = merge(ref_mem[64], 32'h0000_BEEF, 4'b0011);
        exp_last_d  = exp_d;
        exp_last_if = exp_i;
        @(negedge clk);

        // Readback of the partial store
        do_txn(1'b1, 1'b0, 4'hF, 32'h100, 32'h0, 2);

        // Continuous requests on both ports: fetch gets in after MAXS data grants
        d_run = 0;
        for (int i = 0; i < 10; i++) begin
            if (d_run == MAXS) begin exp_o[i] = 0; d_run = 0; end
            else begin exp_o[i] = 1; d_run++; end
        end
        ack_delay = $urandom_range(1, 3);
        d_we = 1'b0;
        d_addr  = {22'h0, 8'($urandom), 2'b00};
        if_addr = {22'h0, 8'($urandom), 2'b00};
        d_req = 1'b1; if_req = 1'b1;
        n = 0; k = 0;
        while (n < 10 && k < 100) begin
            @(posedge clk);
            @(negedge clk);
            k++;
            if (d_done) begin
                got[n] = 1;
                check("cont_d_rdata", d_rdata, ref_mem[d_addr[9:2]]);
                exp_last_d = ref_mem[d_addr[9:2]];
                d_addr = {22'h0, 8'($urandom), 2'b00};
                n++;
            end else if (if_done) begin
                got[n] = 0;
                check("cont_if_rdata", if_rdata, ref_mem[if_addr[9:2]]);
                exp_last_if = ref_mem[if_addr[9:2]];
                if_addr = {22'h0, 8'($urandom), 2'b00};
                n++;
            end
            if (n == 10) begin d_req = 1'b0; if_req = 1'b0; end
        end
        check("cont_count", n, 10);
        for (int i = 0; i < 10; i++) check($sformatf("cont_order_%0d", i), got[i], exp_o[i]);
        d_req = 1'b0; if_req = 1'b0;
        @(negedge clk);

        // Misaligned load: no memory access, error after two cycles
        do_txn(1'b1, 1'b0, 4'hF, 32'h102, 32'h0, 1);

        // Memory never acks, then ack exactly at the timeout cycle
        do_txn(1'b0, 1'b0, 4'hF, 32'h48, 32'h0, 0);
        do_txn(1'b0, 1'b0, 4'hF, 32'h4C, 32'h0, TMO);

        // Reset pulse in the middle of a data transaction
        ack_delay = 0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
        @(posedge clk);
        @(negedge clk);
        check("rstmid_mem_req_before", mem_req, 1);
        @(posedge clk);
        @(negedge clk);
        #2 nrst = 1'b0;
        #1;
        check("rstmid_mem_req_async", mem_req, 0);
        check("rstmid_d_done", d_done, 0);
        @(negedge clk);
        check("rstmid_d_done_held", d_done, 0);
        check("rstmid_mem_req_held", mem_req, 0);
        exp_last_if = '0;
        exp_last_d  = '0;
        nrst = 1'b1;
        do_txn(1'b1, 1'b0, 4'hF, 32'h80, 32'h0, 1);

        // Randomized single transactions
        for (int t = 0; t < 24; t++) begin
            is_d = 1'($urandom_range(0, 1));
            we   = is_d && ($urandom_range(0, 1) == 1);
            a    = {22'h0, 8'($urandom), 2'b00};
            if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
            do_txn(is_d, we, 4'($urandom_range(1, 15)), a, $urandom,
                   ($urandom_range(0, 4) == 0) ? TMO + 1 : $urandom_range(1, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
